// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between a pixel engine (0) and a host (1).
// Bursts are capped at MAX_BURST beats only while the other requester is waiting.
module ram_port_arbiter #(
   parameter int unsigned ADDR_SIZE = 16,
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [ADDR_SIZE-1:0] addr0,
   input  logic [ADDR_SIZE-1:0] addr1,
   input  logic [DATA_SIZE-1:0] wdata0,
   input  logic [DATA_SIZE-1:0] wdata1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 rvalid0,
   output logic                 rvalid1,
   output logic [DATA_SIZE-1:0] rdata0,
   output logic [DATA_SIZE-1:0] rdata1,
   output logic [ADDR_SIZE-1:0] addr_A,
   output logic [DATA_SIZE-1:0] data_in_A,
   output logic                 w_e_A,
   input  logic [DATA_SIZE-1:0] data_out_A
);

   localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, G0, G1} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic                 last_served;
   logic [ADDR_SIZE-1:0] addr_hold;
   logic                 acc0;
   logic                 acc1;
   logic                 burst_end;

   assign gnt0      = (state == G0);
   assign gnt1      = (state == G1);
   assign acc0      = req0 && gnt0;
   assign acc1      = req1 && gnt1;
   assign burst_end = (cnt == CNT_LAST);
   assign rdata0    = data_out_A;
   assign rdata1    = data_out_A;

   // RAM port A follows the granted requester; address holds when no beat is accepted
   always_comb begin
      addr_A    = addr_hold;
      w_e_A     = 1'b0;
      data_in_A = (state == G1) ? wdata1 : wdata0;
      if (acc0) begin
         addr_A = addr0;
         w_e_A  = we0;
      end else if (acc1) begin
         addr_A = addr1;
         w_e_A  = we1;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state       <= IDLE;
         cnt         <= '0;
         last_served <= 1'b1;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         addr_hold   <= '0;
      end else begin
         rvalid0 <= acc0 && !we0;
         rvalid1 <= acc1 && !we1;
         if (acc0) begin
            addr_hold <= addr0;
         end else if (acc1) begin
            addr_hold <= addr1;
         end

         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (req0 && req1) begin
                  state <= last_served ? G0 : G1;
               end else if (req0) begin
                  state <= G0;
               end else if (req1) begin
                  state <= G1;
               end
            end
            G0: begin
               if (!req0) begin
                  cnt         <= '0;
                  last_served <= 1'b0;
                  state       <= req1 ? G1 : IDLE;
               end else if (burst_end) begin
                  // uncontended bursts simply wrap the counter and keep the grant
                  cnt <= '0;
                  if (req1) begin
                     state       <= G1;
                     last_served <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            G1: begin
               if (!req1) begin
                  cnt         <= '0;
                  last_served <= 1'b1;
                  state       <= req0 ? G0 : IDLE;
               end else if (burst_end) begin
                  cnt <= '0;
                  if (req0) begin
                     state       <= G0;
                     last_served <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single read/write port A of the dual-port frame RAM between two requesters: requester 0 (pixel/processing engine) and requester 1 (configuration/host side).
- Round-robin arbitration with bounded bursts, so neither side can starve the other.
- Drives the RAM port A address, write data and write enable, and routes the read data back with a valid strobe.
- Port B of the RAM is not handled by this block.

Parameters:
- ADDR_SIZE, 16, address width of RAM port A.
- DATA_SIZE, 32, data width of RAM port A.
- MAX_BURST, 8, maximum consecutive accepted beats per grant while the other requester is waiting. Must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous reset, active low.
- req0 / req1  in  1  requester N wants a beat this cycle.
- we0 / we1  in  1  beat is a write (1) or a read (0).
- addr0 / addr1  in  ADDR_SIZE  beat address.
- wdata0 / wdata1  in  DATA_SIZE  write data.
- gnt0 / gnt1  out  1  registered grant; at most one is high.
- rvalid0 / rvalid1  out  1  read data valid for requester N.
- rdata0 / rdata1  out  DATA_SIZE  read data; equal to data_out_A.
- addr_A  out  ADDR_SIZE  to RAM port A address.
- data_in_A  out  DATA_SIZE  to RAM port A write data.
- w_e_A  out  1  to RAM port A write enable.
- data_out_A  in  DATA_SIZE  from RAM port A; synchronous read, valid the cycle after the address edge.

Behaviour:
- Reset (asynchronous, nRST low):
  - state IDLE; gnt0 = gnt1 = 0; rvalid0 = rvalid1 = 0; burst counter = 0.
  - last_served = 1, so requester 0 wins the first tie.
  - w_e_A = 0 and addr_A = 0 while IDLE.
  - Reset in mid-burst aborts the burst. A read accepted in the cycle before reset returns no rvalid.
- FSM states: IDLE, G0, G1. gntN = (state == GN).
- Beat acceptance: a beat is accepted in any cycle where reqN && gntN.
- RAM port drive (combinational from the granted requester):
  - addr_A = addrN; data_in_A = wdataN; w_e_A = reqN && gntN && weN.
  - In IDLE, or when the granted requester has req low: w_e_A = 0, addr_A holds its last value.
- Read return:
  - rvalidN is registered: high exactly one cycle after an accepted read by requester N.
  - rdataN = data_out_A, no extra latency.
  - Writes never produce rvalid.
- IDLE transitions:
  - req0 && req1: grant the requester that is not last_served.
  - Otherwise grant whichever requester is asserting req. Stay IDLE if neither is.
  - Grant latency: gnt rises 1 cycle after req is first seen high.
- In GN:
  - Counter increments on each accepted beat and clears on every state change.
  - req of the owner low: go to the other grant state if its req is high, else IDLE; last_served = N.
  - Counter reaches MAX_BURST-1 on an accepted beat and the other req is high: switch to the other grant state at that edge; last_served = N.
  - Counter reaches MAX_BURST-1 and the other req is low: stay in GN, counter wraps to 0 (unlimited burst while uncontended).
- Grant handover:
  - Handover takes effect at the edge after the deciding cycle; no bubble cycle when switching G0 to G1.
  - The beat accepted in the deciding cycle completes normally; its rvalid still goes to the original owner.
- Requester rules:
  - A requester must hold req, we, addr and wdata stable until its grant is seen.
  - Dropping req while granted releases the grant at the next edge.
- Invariants: gnt0 && gnt1 is never high; w_e_A is never high without a grant.

Test Plan:
- Reset then idle: nRST low for 2 cycles, then high with no req -> gnt0 = gnt1 = 0, w_e_A = 0, rvalid0 = rvalid1 = 0 throughout.
- Single write/read by requester 0:
  - Write addr0 = 0x0000, wdata0 = 245: gnt0 rises 1 cycle after req0 and w_e_A pulses one cycle with addr_A = 0x0000.
  - Then a read of 0x0000: rvalid0 is high 1 cycle after acceptance with rdata0 = 245.
- Simultaneous first request: req0 and req1 rise in the same cycle after reset -> gnt0 first (last_served reset to 1). Requester 1 is granted after requester 0 drops req.
- Burst fairness:
  - req0 and req1 both held high with MAX_BURST = 8 -> gnt0 for exactly 8 accepted beats, then gnt1 for 8, alternating.
  - No cycle has both grants high; no idle cycle between bursts.
- Uncontended long burst: req0 high for 20 beats with req1 low -> gnt0 stays high for all 20 beats; counter wraps without a grant drop.
- Reset mid-burst:
  - Pulse nRST low during a read burst by requester 1 -> gnt1 and rvalid1 drop immediately (asynchronous).
  - After release, the first tie is again granted to requester 0.
